// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
//
// Serial TDM frame demultiplexer. A frame is N_CH consecutive slots of W bits,
// each sent MSB first on din. A sync pulse marks the first bit of slot 0. Each
// completed slot is written to its own W-bit slice of ch_data and announced
// with a one-cycle ch_valid pulse. frame_done pulses when the last slot lands.
// A sync seen inside a frame flags sync_err and restarts the frame on that bit.
//
// Ports
//   clk         in   1        single clock, rising edge
//   rst         in   1        synchronous active-high reset
//   din         in   1        serial data bit, MSB of each slot first
//   din_en      in   1        din/sync qualifier; when low nothing advances
//   sync        in   1        first bit of slot 0 (qualified by din_en)
//   ch_data     out  N_CH*W   per-channel words, channel k at [k*W +: W]
//   ch_valid    out  N_CH     one-cycle pulse when a channel slice updates
//   frame_done  out  1        one-cycle pulse when slot N_CH-1 completes
//   sync_err    out  1        one-cycle pulse on a sync seen mid-frame
//   busy        out  1        high while a frame is being collected
// -----------------------------------------------------------------------------
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_en,
    input  logic              sync,
    output logic [N_CH*W-1:0] ch_data,
    output logic [N_CH-1:0]   ch_valid,
    output logic              frame_done,
    output logic              sync_err,
    output logic              busy
);

    localparam int BW = $clog2(W + 1);
    localparam int CW = $clog2(N_CH);
    // Only the first W-1 bits of a slot need storing; the W-th bit comes
    // straight from din on the cycle the word is written out.
    localparam int SW = W - 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]    state;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] ch_cnt;
    logic [SW-1:0] shreg;
    logic          last_bit;
    logic          last_slot;

    function automatic logic [W-1:0] assemble(input logic [SW-1:0] sr, input logic b);
        return {sr, b};
    endfunction

    assign last_bit  = (bit_cnt == BW'(W - 1));
    assign last_slot = (ch_cnt == CW'(N_CH - 1));
    assign busy      = (state == RECV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            ch_cnt     <= '0;
            shreg      <= '0;
            ch_data    <= '0;
            ch_valid   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            ch_valid   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (din_en) begin
                case (state)
                    IDLE: begin
                        if (sync) begin
                            state   <= RECV;
                            shreg   <= SW'(din);
                            bit_cnt <= BW'(1);
                            ch_cnt  <= '0;
                        end
                    end
                    RECV: begin
                        if (sync) begin
                            // Sync wins even on the frame's final bit: the
                            // partial slot is dropped, earlier slices are kept.
                            sync_err <= 1'b1;
                            shreg    <= SW'(din);
                            bit_cnt  <= BW'(1);
                            ch_cnt   <= '0;
                        end else if (last_bit) begin
                            for (int k = 0; k < N_CH; k++) begin
                                if (ch_cnt == CW'(k)) begin
                                    ch_data[k*W +: W] <= assemble(shreg, din);
                                    ch_valid[k]       <= 1'b1;
                                end
                            end
                            bit_cnt <= '0;
                            if (last_slot) begin
                                ch_cnt     <= '0;
                                frame_done <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                ch_cnt <= ch_cnt + CW'(1);
                            end
                        end else begin
                            shreg   <= SW'(assemble(shreg, din));
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
//
// Directed bench for tdm_demux with N_CH=4, W=8. Every enabled bit is followed
// by a check of the pulse/busy flags against hand-derived values; channel
// words are checked after each completed slot and after each scenario.
// -----------------------------------------------------------------------------
module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic              clk;
    logic              rst;
    logic              din;
    logic              din_en;
    logic              sync;
    logic [N_CH*W-1:0] ch_data;
    logic [N_CH-1:0]   ch_valid;
    logic              frame_done;
    logic              sync_err;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;
    bit gap_on = 1'b0;
    int gap_cnt = 0;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_en     (din_en),
        .sync       (sync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs and return 1 time unit after the sampling edge.
    task automatic step(input logic en, input logic s, input logic d);
        din_en = en;
        sync   = s;
        din    = d;
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {ch_valid[3:0], frame_done, sync_err, busy}.
    task automatic send_bit(input logic s, input logic d, input logic [3:0] ev,
                            input logic ef, input logic ee, input logic eb,
                            input string tag);
        step(1'b1, s, d);
        chk(tag, {25'd0, ch_valid, frame_done, sync_err, busy}, {25'd0, ev, ef, ee, eb});
        if (gap_on) begin
            gap_cnt++;
            if (gap_cnt == 5) begin
                gap_cnt = 0;
                repeat (3) begin
                    step(1'b0, 1'b1, 1'b1);
                    chk({tag, "_gap"}, {25'd0, ch_valid, frame_done, sync_err, busy},
                        {25'd0, 4'b0000, 1'b0, 1'b0, eb});
                end
            end
        end
    endtask

    // Send bits [7-start .. 0] of byte b as slot k; sync on bit 0 if requested.
    task automatic send_slot(input int k, input logic [7:0] b, input logic first_sync,
                             input int start, input string tag);
        logic last;
        for (int i = start; i < 8; i++) begin
            last = (i == 7);
            send_bit(first_sync && (i == 0), b[7-i],
                     last ? 4'(1 << k) : 4'b0000,
                     last && (k == 3), 1'b0, !(last && (k == 3)), tag);
        end
        chk({tag, "_slot"}, {24'd0, ch_data[k*8 +: 8]}, {24'd0, b});
    endtask

    task automatic send_frame(input logic [31:0] w, input string tag);
        for (int k = 0; k < 4; k++)
            send_slot(k, w[k*8 +: 8], k == 0, 0, tag);
    endtask

    initial begin
        rst = 1'b1; din_en = 1'b0; sync = 1'b0; din = 1'b0;

        // Reset has priority over an enabled sync.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_data", ch_data, 32'h0);
        chk("rst_flags", {25'd0, ch_valid, frame_done, sync_err, busy}, 32'h0);
        rst = 1'b0;

        // No sync while idle: everything discarded.
        for (int i = 0; i < 16; i++)
            send_bit(1'b0, i[0] ^ i[2], 4'b0, 1'b0, 1'b0, 1'b0, "nosync");
        chk("nosync_data", ch_data, 32'h0);

        // Clean frame.
        send_frame(32'h01FF3CA5, "clean");
        chk("clean_data", ch_data, 32'h01FF3CA5);

        // Back-to-back frame, sync right after frame_done.
        send_frame(32'h44332211, "b2b");
        chk("b2b_data", ch_data, 32'h44332211);

        // Gapped frame.
        gap_on = 1'b1; gap_cnt = 0;
        send_frame(32'h01FF3CA5, "gap");
        gap_on = 1'b0;
        chk("gap_data", ch_data, 32'h01FF3CA5);

        // Resync on bit 3 of slot 2.
        send_slot(0, 8'h5A, 1'b1, 0, "resync");
        send_slot(1, 8'hC3, 1'b0, 0, "resync");
        send_bit(1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1, "resync_s2");
        send_bit(1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, "resync_s2");
        send_bit(1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1, "resync_s2");
        send_bit(1'b1, 1'b1, 4'b0, 1'b0, 1'b1, 1'b1, "resync_err");
        chk("resync_keep", ch_data, 32'h01FFC35A);
        send_slot(0, 8'h96, 1'b0, 1, "restart");
        chk("restart_data", ch_data, 32'h01FFC396);
        send_slot(1, 8'h11, 1'b0, 0, "restart");
        send_slot(2, 8'h22, 1'b0, 0, "restart");
        send_slot(3, 8'h33, 1'b0, 0, "restart");
        chk("restart_end", ch_data, 32'h33221196);

        // Sync on the frame's last bit counts as mid-frame.
        send_slot(0, 8'hAA, 1'b1, 0, "lastsync");
        send_slot(1, 8'hBB, 1'b0, 0, "lastsync");
        send_slot(2, 8'hCC, 1'b0, 0, "lastsync");
        for (int i = 0; i < 7; i++)
            send_bit(1'b0, i[0], 4'b0, 1'b0, 1'b0, 1'b1, "lastsync_s3");
        send_bit(1'b1, 1'b1, 4'b0, 1'b0, 1'b1, 1'b1, "lastsync_err");
        chk("lastsync_keep", ch_data, 32'h33CCBBAA);
        send_slot(0, 8'hE7, 1'b0, 1, "lastsync_re");
        chk("lastsync_re_data", ch_data, 32'h33CCBBE7);

        // Reset during slot 1.
        for (int i = 0; i < 3; i++)
            send_bit(1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1, "midrst_s1");
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk("midrst_data", ch_data, 32'h0);
        chk("midrst_flags", {25'd0, ch_valid, frame_done, sync_err, busy}, 32'h0);
        for (int i = 0; i < 16; i++)
            send_bit(1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0, "midrst_after");
        chk("midrst_after_data", ch_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
